// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I decode types, encodings and helpers
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // ALU_ADDPC tells EX to take the PC as operand A (auipc)
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_ADDPC = 4'd11
  } alu_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        jalr;
    alu_ctrl_t   alu_control;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // funct3 to ALU operation; alt selects sub/sra
  function automatic alu_ctrl_t alu_op(input logic [2:0] funct3, input logic alt);
    alu_ctrl_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - immediate sign-extender for the I/S/B/J/U formats
module imm_extend
  import rv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_src_t    imm_src,
  output logic [31:0] imm_ext
);

  // Reassemble and sign-extend the immediate selected by imm_src
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm_ext = {instr[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational opcode decode into the EX control bundle
module main_decoder
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl,
  output imm_src_t   imm_src
);

  // Map opcode to controls; unknown opcodes only raise illegal
  always_comb begin
    ctrl    = CTRL_NOP;
    imm_src = IMM_I;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_op(funct3, funct7_5 && (funct3 == 3'b101));
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_OP: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_op(funct3, funct7_5);
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_src          = IMM_B;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_PASSB;
        imm_src          = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADDPC;
        imm_src          = IMM_U;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with load-use detection and ID/EX register
module id_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            StallD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [31:0]     ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            JalrE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic            ValidE,
  output logic            IllegalE
);

  ctrl_t       ctrl_d;
  ctrl_t       ctrl_e;
  imm_src_t    imm_src_d;
  logic [31:0] imm_ext_d;
  logic        rs1_used;
  logic        rs2_used;
  logic        load_in_e;

  main_decoder u_main_decoder (
    .opcode   (InstrD[6:0]),
    .funct3   (InstrD[14:12]),
    .funct7_5 (InstrD[30]),
    .ctrl     (ctrl_d),
    .imm_src  (imm_src_d)
  );

  imm_extend u_imm_extend (
    .instr   (InstrD[31:7]),
    .imm_src (imm_src_d),
    .imm_ext (imm_ext_d)
  );

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  assign rs1_used  = uses_rs1(InstrD[6:0]);
  assign rs2_used  = uses_rs2(InstrD[6:0]);
  assign load_in_e = ValidE && (ctrl_e.result_src == RES_MEM) && (RdE != 5'd0);
  assign StallD    = load_in_e && ValidD &&
                     (((RdE == Rs1D) && rs1_used) || ((RdE == Rs2D) && rs2_used));

  // Valid and controls: flush beats hold, hold beats the load-use bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e <= CTRL_NOP;
      ValidE <= 1'b0;
    end else if (FlushE) begin
      ctrl_e <= CTRL_NOP;
      ValidE <= 1'b0;
    end else if (!StallE) begin
      if (StallD) begin
        ctrl_e <= CTRL_NOP;
        ValidE <= 1'b0;
      end else begin
        ctrl_e <= ValidD ? ctrl_d : CTRL_NOP;
        ValidE <= ValidD;
      end
    end
  end

  // Operand and address fields; left untouched under bubbles since nothing consumes them
  always_ff @(posedge clk) begin
    if (rst) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= RESET_PC;
      PCPlus4E <= RESET_PC;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      Funct3E  <= '0;
    end else if (!FlushE && !StallE && !StallD) begin
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= imm_ext_d;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= InstrD[11:7];
      Funct3E  <= InstrD[14:12];
    end
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign BranchE     = ctrl_e.branch;
  assign JumpE       = ctrl_e.jump;
  assign JalrE       = ctrl_e.jalr;
  assign ResultSrcE  = ctrl_e.result_src;
  assign ALUControlE = ctrl_e.alu_control;
  assign IllegalE    = ctrl_e.illegal;

endmodule
